// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file and its mux tree.
package regfile_pkg;

  localparam int MAX_NREAD = 4;
  localparam int MAX_AW    = 8;

  // Index width for a power-of-two entry count.
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Read request as carried down the pipeline towards the operand latches.
  typedef struct packed {
    logic [MAX_AW-1:0] addr;
    logic              en;
  } rd_port_t;

endpackage

// File: rtl/muxn_1.sv
// Generic power-of-two N:1 multiplexer built recursively from 2:1 stages.
// The top select bit picks between two half-size trees.
module muxn_1
  import regfile_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32
) (
  output logic [WIDTH-1:0]             mux_out,
  input  logic [DEPTH-1:0][WIDTH-1:0]  mux_in,
  input  logic [addr_w(DEPTH)-1:0]     sel
);

  localparam int SW   = addr_w(DEPTH);
  localparam int HALF = DEPTH / 2;

  if (DEPTH == 2) begin : g_leaf
    // Final 2:1 stage.
    always_comb mux_out = sel[0] ? mux_in[1] : mux_in[0];
  end else begin : g_node
    logic [WIDTH-1:0] lo_out;
    logic [WIDTH-1:0] hi_out;

    muxn_1 #(.WIDTH(WIDTH), .DEPTH(HALF)) u_lo (
      .mux_out (lo_out),
      .mux_in  (mux_in[HALF-1:0]),
      .sel     (sel[SW-2:0])
    );

    muxn_1 #(.WIDTH(WIDTH), .DEPTH(HALF)) u_hi (
      .mux_out (hi_out),
      .mux_in  (mux_in[DEPTH-1:HALF]),
      .sel     (sel[SW-2:0])
    );

    // Top-level 2:1 stage on the most significant select bit.
    always_comb mux_out = sel[SW-1] ? hi_out : lo_out;
  end

endmodule

// File: rtl/regfile_nr.sv
// Parametrised multi-read-port register file with a hardwired zero entry.
// Reads are registered (1-cycle latency) with per-port enables.
// Optional feature: define REGFILE_BYPASS_EN for write-first behaviour on a
// same-edge read/write of the same non-zero address; default is read-first.
module regfile_nr
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_IDX = DEPTH - 1
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  wr_en,
  input  logic [addr_w(DEPTH)-1:0]              wr_addr,
  input  logic [WIDTH-1:0]                      wr_data,
  input  logic [NREAD-1:0]                      rd_en,
  input  logic [NREAD-1:0][addr_w(DEPTH)-1:0]   rd_addr,
  output logic [NREAD-1:0][WIDTH-1:0]           rd_data,
  output logic [NREAD-1:0]                      rd_valid
);

  localparam int          AW = addr_w(DEPTH);
  localparam int unsigned ZI = ZERO_IDX;

  logic [WIDTH-1:0]             mem [DEPTH];
  logic [DEPTH-1:0][WIDTH-1:0]  entries;
  logic [NREAD-1:0][WIDTH-1:0]  tree_out;
  logic [NREAD-1:0][WIDTH-1:0]  next_data;

  // Storage update: synchronous clear, writes to the zero entry are dropped.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en && (wr_addr != AW'(ZI))) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Tree inputs: the zero entry is a constant, never the stored word.
  always_comb begin
    entries = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entries[i] = (i == ZI) ? '0 : mem[i];
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    muxn_1 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tree (
      .mux_out (tree_out[p]),
      .mux_in  (entries),
      .sel     (rd_addr[p])
    );
  end

`ifdef REGFILE_BYPASS_EN
  logic [NREAD-1:0] byp_hit;

  // Write-first: forward wr_data past the tree on a same-address hit.
  always_comb begin
    byp_hit   = '0;
    next_data = tree_out;
    for (int unsigned p = 0; p < NREAD; p++) begin
      byp_hit[p]   = wr_en && (wr_addr == rd_addr[p]) && (wr_addr != AW'(ZI));
      next_data[p] = byp_hit[p] ? wr_data : tree_out[p];
    end
  end
`else
  // Read-first: the tree output is the registered value as-is.
  always_comb next_data = tree_out;
`endif

  // Output registers: data holds when disabled, valid tracks the enable.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_valid <= '0;
    end else begin
      for (int unsigned p = 0; p < NREAD; p++) begin
        rd_valid[p] <= rd_en[p];
        if (rd_en[p]) rd_data[p] <= next_data[p];
      end
    end
  end

endmodule

// File: tb/tb_regfile_nr.sv
// Directed self-checking bench for regfile_nr: default configuration plus a
// WIDTH=32 / DEPTH=16 / NREAD=3 / ZERO_IDX=0 instance on the same clock.
module tb_regfile_nr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Instance A: defaults (64 x 32, 2 ports, zero at 31)
  logic              a_reset_n;
  logic              a_wr_en;
  logic [4:0]        a_wr_addr;
  logic [63:0]       a_wr_data;
  logic [1:0]        a_rd_en;
  logic [1:0][4:0]   a_rd_addr;
  logic [1:0][63:0]  a_rd_data;
  logic [1:0]        a_rd_valid;

  // Instance B: 32 x 16, 3 ports, zero at 0
  logic              b_reset_n;
  logic              b_wr_en;
  logic [3:0]        b_wr_addr;
  logic [31:0]       b_wr_data;
  logic [2:0]        b_rd_en;
  logic [2:0][3:0]   b_rd_addr;
  logic [2:0][31:0]  b_rd_data;
  logic [2:0]        b_rd_valid;

  regfile_nr u_dut_a (
    .clk      (clk),
    .reset_n  (a_reset_n),
    .wr_en    (a_wr_en),
    .wr_addr  (a_wr_addr),
    .wr_data  (a_wr_data),
    .rd_en    (a_rd_en),
    .rd_addr  (a_rd_addr),
    .rd_data  (a_rd_data),
    .rd_valid (a_rd_valid)
  );

  regfile_nr #(.WIDTH(32), .DEPTH(16), .NREAD(3), .ZERO_IDX(0)) u_dut_b (
    .clk      (clk),
    .reset_n  (b_reset_n),
    .wr_en    (b_wr_en),
    .wr_addr  (b_wr_addr),
    .wr_data  (b_wr_data),
    .rd_en    (b_rd_en),
    .rd_addr  (b_rd_addr),
    .rd_data  (b_rd_data),
    .rd_valid (b_rd_valid)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] a_exp(input int a);
    return (a == 31) ? 64'h0 : 64'hA5A5_0000_0000_0000 + 64'(a);
  endfunction

  function automatic logic [31:0] b_exp(input int a);
    return (a == 0) ? 32'h0 : 32'hA5A5_0000 + 32'(a);
  endfunction

  logic [63:0] coll_exp;

  initial begin
`ifdef REGFILE_BYPASS_EN
    coll_exp = 64'h22;
`else
    coll_exp = 64'h11;
`endif
    a_reset_n = 1'b0; a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 64'hFF;
    a_rd_en = '0; a_rd_addr = '0;
    b_reset_n = 1'b0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
    b_rd_en = '0; b_rd_addr = '0;

    // Reset held two cycles with a write pending
    tick();
    check("rst_data", 64'(a_rd_data), 64'h0);
    check("rst_valid", 64'(a_rd_valid), 64'h0);
    tick();
    a_reset_n = 1'b1; a_wr_en = 1'b0;
    a_rd_en = 2'b01; a_rd_addr[0] = 5'd3;
    tick();
    check("rst_rd3_data", a_rd_data[0], 64'h0);
    check("rst_rd3_valid", 64'(a_rd_valid[0]), 64'h1);
    a_rd_en = '0;
    tick();

    // Fill 0..30
    a_wr_en = 1'b1;
    for (int i = 0; i < 31; i++) begin
      a_wr_addr = 5'(i);
      a_wr_data = 64'hA5A5_0000_0000_0000 + 64'(i);
      tick();
    end
    a_wr_en = 1'b0;

    // Sweep: port 0 ascending, port 1 descending
    a_rd_en = 2'b11;
    for (int i = 0; i < 32; i++) begin
      a_rd_addr[0] = 5'(i);
      a_rd_addr[1] = 5'(31 - i);
      tick();
      check($sformatf("a_sweep_p0_%0d", i), a_rd_data[0], a_exp(i));
      check($sformatf("a_sweep_p1_%0d", 31 - i), a_rd_data[1], a_exp(31 - i));
      check("a_sweep_valid", 64'(a_rd_valid), 64'h3);
    end

    // Zero register: write to 31 while reading 31, then read again
    a_wr_en = 1'b1; a_wr_addr = 5'd31; a_wr_data = 64'hDEAD_BEEF;
    a_rd_addr[0] = 5'd31; a_rd_addr[1] = 5'd31;
    tick();
    check("zero_same_p0", a_rd_data[0], 64'h0);
    check("zero_same_p1", a_rd_data[1], 64'h0);
    a_wr_en = 1'b0;
    tick();
    check("zero_next_p0", a_rd_data[0], 64'h0);
    check("zero_next_p1", a_rd_data[1], 64'h0);
    a_rd_en = '0;

    // Collision on addr 5
    a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 64'h11;
    tick();
    a_wr_data = 64'h22;
    a_rd_en = 2'b10; a_rd_addr[1] = 5'd5;
    tick();
    check("coll_same", a_rd_data[1], coll_exp);
    check("coll_p0_idle", 64'(a_rd_valid[0]), 64'h0);
    a_wr_en = 1'b0;
    tick();
    check("coll_next", a_rd_data[1], 64'h22);

    // Enable hold on port 0
    a_rd_en = '0;
    a_wr_en = 1'b1; a_wr_addr = 5'd2; a_wr_data = 64'h7;
    tick();
    a_wr_en = 1'b0;
    a_rd_en = 2'b01; a_rd_addr[0] = 5'd2;
    tick();
    check("hold_rd", a_rd_data[0], 64'h7);
    check("hold_rd_valid", 64'(a_rd_valid[0]), 64'h1);
    a_rd_en = '0;
    a_wr_en = 1'b1; a_wr_data = 64'h9;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_data_%0d", i), a_rd_data[0], 64'h7);
      check($sformatf("hold_valid_%0d", i), 64'(a_rd_valid[0]), 64'h0);
    end
    a_wr_en = 1'b0;
    a_rd_en = 2'b01;
    tick();
    check("hold_reread", a_rd_data[0], 64'h9);

    // Reset mid-stream: valid from last accepted read clears at reset edge
    a_reset_n = 1'b0;
    tick();
    check("mid_rst_data", a_rd_data[0], 64'h0);
    check("mid_rst_valid", 64'(a_rd_valid), 64'h0);
    a_reset_n = 1'b1;
    a_rd_addr[0] = 5'd10;
    tick();
    check("post_rst_mem", a_rd_data[0], 64'h0);
    a_rd_en = '0;

    // Instance B: reset, fill 0..15 (0 discarded), sweep on three ports
    tick();
    b_reset_n = 1'b1;
    b_wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b_wr_addr = 4'(i);
      b_wr_data = 32'hA5A5_0000 + 32'(i);
      tick();
    end
    b_wr_en = 1'b0;
    b_rd_en = 3'b111;
    for (int i = 0; i < 16; i++) begin
      b_rd_addr[0] = 4'(i);
      b_rd_addr[1] = 4'(15 - i);
      b_rd_addr[2] = 4'((i + 5) % 16);
      tick();
      check($sformatf("b_sweep_p0_%0d", i), 64'(b_rd_data[0]), 64'(b_exp(i)));
      check($sformatf("b_sweep_p1_%0d", 15 - i), 64'(b_rd_data[1]), 64'(b_exp(15 - i)));
      check($sformatf("b_sweep_p2_%0d", (i + 5) % 16), 64'(b_rd_data[2]), 64'(b_exp((i + 5) % 16)));
      check("b_sweep_valid", 64'(b_rd_valid), 64'h7);
    end
    b_rd_en = '0;
    tick();
    check("b_idle_valid", 64'(b_rd_valid), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_nr.md
# regfile_nr

Parametrised multi-read-port register file: the next generation of the CPU's fixed 32-entry, 32:1-mux-read register storage. Width, depth and read-port count are generic, reads are registered with one-cycle latency and per-port enables, and one entry is a hardwired zero register. The block sits in the decode stage. It feeds operand latches and takes writeback from the final pipeline stage.

## Interface
- WIDTH, 64, data bits per entry
- DEPTH, 32, number of entries; power of two, 2..256
- NREAD, 2, number of independent read ports, 1..4
- ZERO_IDX, DEPTH-1, index of the hardwired-zero entry; reads always return 0, writes are discarded
- clk  input  1  sole clock; all state updates on posedge
- reset_n  input  1  synchronous, active-low reset, sampled on posedge clk
- wr_en  input  1  write strobe
- wr_addr  input  $clog2(DEPTH)  write index
- wr_data  input  WIDTH  write data
- rd_en  input  NREAD  per-port read enable
- rd_addr  input  NREAD x $clog2(DEPTH)  per-port read index, packed [NREAD-1:0][AW-1:0]
- rd_data  output  NREAD x WIDTH  per-port registered read data, packed [NREAD-1:0][WIDTH-1:0]
- rd_valid  output  NREAD  high the cycle after an accepted read

## Operation
- Storage: DEPTH x WIDTH flops. Entry ZERO_IDX is not stored; it is a constant 0.
- Write: on posedge with reset_n=1, wr_en=1 and wr_addr!=ZERO_IDX, mem[wr_addr] <= wr_data. A write to ZERO_IDX is a no-op.
- Read: on posedge with reset_n=1 and rd_en[p]=1:
  - rd_data[p] <= selected entry.
  - rd_valid[p] <= 1.
- When rd_en[p]=0, rd_data[p] holds its last value and rd_valid[p] <= 0.
- Selection is a log2(DEPTH)-level tree of 2:1 stages, one tree per port.
- Ports are independent. Any number of ports may read the same address in the same cycle.
- Read of ZERO_IDX returns all-zero, including when a same-cycle write targets ZERO_IDX.
- Same-cycle read and write of the same address: governed by Configuration.
- Reset (reset_n=0 at posedge):
  - All mem entries <= 0, rd_data <= 0, rd_valid <= 0.
  - Reset dominates wr_en and rd_en in that cycle.
- Reset mid-stream: a read accepted in the cycle before reset still shows rd_valid=1 for exactly one cycle. If reset asserts at that next edge, both the valid and the data clear at that edge.
- Out-of-range addresses cannot occur because DEPTH is a power of two.

## Timing
- Write latency: 1 cycle. Data is visible to a read issued on the following edge.
- Read latency: 1 cycle, from posedge sampling rd_addr to rd_data/rd_valid updating at that same posedge.
- No back-pressure: a read is issued every cycle that rd_en is high.
- Combinational path: rd_addr -> tree -> rd_data D-input. There is no combinational input-to-output path.
- Reset values: rd_data = 0, rd_valid = 0, every mem entry = 0.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Write-first behaviour. A read at the same edge as a write to the same non-zero address returns wr_data.
  - Implemented as a per-port address compare plus a 2:1 select after the tree.
- REGFILE_BYPASS_EN undefined:
  - Read-first behaviour. Such a read returns the pre-write value.
  - The new value is visible from the next edge.
  - No compare logic is instantiated.

## Structure
- Package regfile_pkg holds:
  - function addr_w(depth), returning $clog2.
  - localparam MAX_NREAD = 4.
  - typedef rd_port_t: addr plus en, for pipeline use.
- Sub-module muxn_1 #(WIDTH, DEPTH) (mux_out, mux_in, sel) is the generic power-of-two mux tree, built recursively from 2:1 stages. It is instantiated once per read port. It replaces the fixed 32:1 composition.
- The top level holds storage, write decode, zero-entry handling, the bypass compare and the output registers.

## Test plan
- Reset:
  - Hold reset_n=0 for 2 cycles with wr_en=1, wr_addr=3, wr_data=64'hFF.
  - Release, then read addr 3 on port 0.
  - Required: rd_data[0]=0 and rd_valid[0]=1 one cycle after the read.
- Fill and sweep:
  - Write mem[i] = 64'hA5A5_0000_0000_0000 + i for i = 0..30.
  - Read every i on both ports.
  - Required: each port returns the written value 1 cycle later.
  - Required: a read of index 31 returns 0.
- Zero register:
  - Write 64'hDEAD_BEEF to addr 31, and read addr 31 on both ports in the same and the next cycle.
  - Required: 0 on all reads.
- Collision, with mem[5]=64'h11:
  - Write 64'h22 to addr 5 while port 1 reads addr 5 at the same edge.
  - Required: 64'h22 with REGFILE_BYPASS_EN defined, 64'h11 without it.
  - Required: a read on the next cycle returns 64'h22 in both builds.
- Enable hold:
  - Port 0 reads addr 2 (value 64'h7), then rd_en[0]=0 for 3 cycles while addr 2 is rewritten to 64'h9.
  - Required: rd_data[0] stays 64'h7 and rd_valid[0]=0 during the hold.
- Parameter sweep:
  - Rerun the fill/sweep with WIDTH=32, DEPTH=16, NREAD=3, ZERO_IDX=0.
  - Required: identical pass criteria, with index 0 reading as zero.
